// File: rtl/hero_sprite_pkg.sv
// Shared constants and types for the hero running-sprite fetch path.
// Latency: n/a (declarations only). Backpressure: n/a.
package hero_sprite_pkg;

  localparam int SPR_W           = 32;
  localparam int SPR_H           = 48;
  localparam int NUM_FRAMES      = 4;
  localparam int TICKS_PER_FRAME = 6;
  localparam int ADDR_W          = 13;
  localparam int FRAME_W         = 2;
  localparam int FRAME_WORDS     = SPR_W * SPR_H;

  typedef logic [2:0] pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX = 3'd0;

  typedef enum logic {
    STAND = 1'b0,
    RUN   = 1'b1
  } anim_state_e;

endpackage

// File: rtl/hero_anim_ctrl.sv
// Run-cycle animation state: frame counter and facing latch, stepped by vsync strobes.
// Latency: updates visible the cycle after vsync_pulse. Backpressure: none, strobe-driven.
module hero_anim_ctrl
  import hero_sprite_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vsync_pulse,
  input  logic               running,
  input  logic               facing_left,
  output logic [FRAME_W-1:0] frame_num,
  output logic               facing
);

  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  anim_state_e        state, state_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic [FRAME_W-1:0] frame_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= STAND;
      tick_cnt  <= '0;
      frame_num <= '0;
      facing    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      frame_num <= frame_nxt;
      if (vsync_pulse)
        facing <= facing_left;
    end
  end

  // Everything holds between strobes; only vsync_pulse cycles move the animation.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    frame_nxt = frame_num;
    if (vsync_pulse) begin
      case (state)
        STAND: begin
          tick_nxt  = '0;
          frame_nxt = '0;
          if (running)
            state_nxt = RUN;
        end
        RUN: begin
          if (!running) begin
            state_nxt = STAND;
            tick_nxt  = '0;
            frame_nxt = '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            frame_nxt = (frame_num == FRAME_LAST) ? '0 : frame_num + 1'b1;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        default: state_nxt = STAND;
      endcase
    end
  end

endmodule

// File: rtl/hero_run_sprite_fetch.sv
// Hero sprite bounding-box test, ROM address generation and colour-index alignment.
// Latency: DrawX/DrawY to index/opaque is 2 cycles. Backpressure: none, pixel-rate stream.
module hero_run_sprite_fetch
  import hero_sprite_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vsync_pulse,
  input  logic               running,
  input  logic               facing_left,
  input  logic [9:0]         hero_x,
  input  logic [9:0]         hero_y,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [ADDR_W-1:0]  rom_addr,
  input  pal_idx_t           rom_data,
  output pal_idx_t           index,
  output logic               opaque,
  output logic [FRAME_W-1:0] frame_num
);

  if (NUM_FRAMES * FRAME_WORDS > (1 << ADDR_W)) begin : g_addr_overflow
    $error("hero_run_sprite_fetch: ADDR_W too small for sprite ROM");
  end
  if (NUM_FRAMES > (1 << FRAME_W) || TICKS_PER_FRAME < 1) begin : g_anim_range
    $error("hero_run_sprite_fetch: animation parameters out of range");
  end

  logic              facing;
  logic [10:0]       dx, dy, col;
  logic              hit_x, hit_y, hit;
  logic [ADDR_W-1:0] addr_calc;
  logic              hit_d1;

  hero_anim_ctrl u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync_pulse (vsync_pulse),
    .running     (running),
    .facing_left (facing_left),
    .frame_num   (frame_num),
    .facing      (facing)
  );

  // 11-bit upper bound so a sprite near the right/bottom edge never wraps back to 0.
  always_comb begin
    dx        = {1'b0, DrawX} - {1'b0, hero_x};
    dy        = {1'b0, DrawY} - {1'b0, hero_y};
    hit_x     = (DrawX >= hero_x) && ({1'b0, DrawX} < ({1'b0, hero_x} + 11'(SPR_W)));
    hit_y     = (DrawY >= hero_y) && ({1'b0, DrawY} < ({1'b0, hero_y} + 11'(SPR_H)));
    hit       = hit_x && hit_y;
    col       = facing ? (11'(SPR_W - 1) - dx) : dx;
    addr_calc = ADDR_W'(frame_num) * ADDR_W'(FRAME_WORDS)
              + ADDR_W'(dy) * ADDR_W'(SPR_W)
              + ADDR_W'(col);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      index    <= TRANSPARENT_IDX;
      opaque   <= 1'b0;
    end else begin
      if (hit)
        rom_addr <= addr_calc;
      hit_d1 <= hit;
      index  <= hit_d1 ? rom_data : TRANSPARENT_IDX;
      opaque <= hit_d1 && (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule
